// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host write port and transmitter launch/complete handshake for uart_tx_fifo_ctrl.
// master = host + transmitter side, slave = the FIFO controller.
interface uart_tx_fifo_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
);
  logic                   wr_en;
  logic [DATA_BITS-1:0]   wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   ovf_clr;
  logic                   tx_start;
  logic [DATA_BITS-1:0]   tx_data;
  logic                   tx_done;
  logic                   busy;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_done,
    input  full, empty, count, overflow, tx_start, tx_data, busy
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_done,
    output full, empty, count, overflow, tx_start, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO ahead of the UART transmitter: buffers host writes and launches
// one frame at a time, waiting for tx_done before popping the next byte.
//
// state     | meaning
// IDLE      | nothing in flight; pops the head byte as soon as the FIFO is non-empty
// LAUNCH    | tx_start is high for this single cycle
// WAIT_DONE | frame in flight; tx_data held until tx_done
module uart_tx_fifo_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_fifo_ctrl_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]           state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count_r;
  logic                 overflow_r;
  logic                 tx_start_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 busy_r;

  logic full_w;
  logic empty_w;
  logic pop;
  logic push;
  logic drop;

  assign full_w  = (count_r == CNT_W'(DEPTH));
  assign empty_w = (count_r == '0);
  assign pop     = (state == IDLE) && !empty_w;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push    = bus.wr_en && (!full_w || pop);
  assign drop    = bus.wr_en && full_w && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop) begin
        overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_r  <= mem[rd_ptr];
            tx_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_r <= 1'b0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = busy_r;
endmodule
